// File: rtl/ndp_pkg.sv
// Shared types and sizing helpers for the NDP reset sequencer.
package ndp_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_HOLD      = 3'd1,
    ST_DIV_START = 3'd2,
    ST_LOCK      = 3'd3,
    ST_READY     = 3'd4,
    ST_SOFT      = 3'd5,
    ST_FAULT     = 3'd6
  } ndp_rst_state_t;

  // Cycles allowed in LOCK before the divider is declared dead.
  function automatic int unsigned ndp_timeout(input int unsigned ratio,
                                              input int unsigned lock_edges);
    return 4 * ratio * lock_edges;
  endfunction

  function automatic int unsigned ndp_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ndp_reset_sync.sv
// Reset-deassertion synchronizer: asynchronous clear, synchronous release.
module ndp_reset_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic synced
);

  logic [STAGES-1:0] chain;

  // Shift a 1 through the chain once reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], 1'b1};
  end

  assign synced = chain[STAGES-1];

endmodule

// File: rtl/ndp_reset_seq.sv
// Power-up / soft-reset sequencer for the NDP clock/reset tree.
module ndp_reset_seq
  import ndp_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned RATIO       = 5,
  parameter int unsigned LOCK_EDGES  = 2
) (
  input  logic       original_clock,
  input  logic       reset_in,
  input  logic       soft_reset_req,
  output logic       soft_reset_ack,
  input  logic       clock_slower_mon,
  output logic       clk_gen_reset_n,
  output logic       ndp_reset_n,
  output logic       ready,
  output logic       error,
  output logic [2:0] state
);

  localparam int unsigned TIMEOUT = ndp_timeout(RATIO, LOCK_EDGES);
  localparam int unsigned CNT_MAX = ndp_max(HOLD_CYCLES, TIMEOUT);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned EW      = $clog2(LOCK_EDGES + 1);

  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT      = CW'(CNT_MAX);
  localparam logic [EW-1:0] EDGE_LAST    = EW'(LOCK_EDGES - 1);
  localparam logic [EW-1:0] EDGE_SAT     = EW'(LOCK_EDGES);

  ndp_rst_state_t cur, nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [EW-1:0]  edges, edges_nxt;
  logic           prev, prev_nxt;
  logic           toggle;
  logic           error_nxt;
  logic           sync_done;

  ndp_reset_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (original_clock),
    .rst_n  (reset_in),
    .synced (sync_done)
  );

  // Next-state, shared hold/timeout counter, edge counter and sticky error.
  always_comb begin
    nxt       = cur;
    cnt_nxt   = cnt;
    edges_nxt = edges;
    prev_nxt  = prev;
    toggle    = clock_slower_mon ^ prev;
    case (cur)
      ST_ASSERT: begin
        if (sync_done) begin
          nxt     = ST_HOLD;
          cnt_nxt = '0;
        end
      end
      ST_HOLD: begin
        if (cnt == HOLD_LAST)    nxt     = ST_DIV_START;
        else if (cnt != CNT_SAT) cnt_nxt = cnt + CW'(1);
      end
      ST_DIV_START: begin
        // Previous sample starts at clk_gen's reset value of clock_slower.
        edges_nxt = '0;
        cnt_nxt   = '0;
        prev_nxt  = 1'b0;
        nxt       = ST_LOCK;
      end
      ST_LOCK: begin
        prev_nxt = clock_slower_mon;
        // Final toggle takes priority over a coincident timeout.
        if (toggle && (edges == EDGE_LAST)) begin
          nxt       = ST_READY;
          edges_nxt = EDGE_SAT;
        end else begin
          if (toggle && (edges != EDGE_SAT)) edges_nxt = edges + EW'(1);
          if (cnt == TIMEOUT_LAST)     nxt     = ST_FAULT;
          else if (cnt != CNT_SAT)     cnt_nxt = cnt + CW'(1);
        end
      end
      ST_READY: begin
        if (soft_reset_req) nxt = ST_SOFT;
      end
      ST_SOFT: begin
        if (!soft_reset_req) begin
          nxt     = ST_HOLD;
          cnt_nxt = '0;
        end
      end
      ST_FAULT: begin
        if (soft_reset_req) nxt = ST_SOFT;
      end
      default: nxt = ST_ASSERT;
    endcase

    error_nxt = error;
    if (nxt == ST_FAULT)     error_nxt = 1'b1;
    else if (nxt == ST_SOFT) error_nxt = 1'b0;
  end

  // State, counters and edge-detect history.
  always_ff @(posedge original_clock or negedge reset_in) begin
    if (!reset_in) begin
      cur   <= ST_ASSERT;
      cnt   <= '0;
      edges <= '0;
      prev  <= 1'b0;
    end else begin
      cur   <= nxt;
      cnt   <= cnt_nxt;
      edges <= edges_nxt;
      prev  <= prev_nxt;
    end
  end

  // Outputs registered from the next state so they line up with state.
  always_ff @(posedge original_clock or negedge reset_in) begin
    if (!reset_in) begin
      clk_gen_reset_n <= 1'b0;
      ndp_reset_n     <= 1'b0;
      ready           <= 1'b0;
      error           <= 1'b0;
      soft_reset_ack  <= 1'b0;
    end else begin
      clk_gen_reset_n <= (nxt == ST_DIV_START) || (nxt == ST_LOCK) || (nxt == ST_READY);
      ndp_reset_n     <= (nxt == ST_READY);
      ready           <= (nxt == ST_READY);
      error           <= error_nxt;
      soft_reset_ack  <= (nxt == ST_SOFT);
    end
  end

  assign state = cur;

endmodule

// File: doc/ndp_reset_seq.md
# ndp_reset_seq

Power-up and soft-reset sequencer for the NDP clock/reset tree. It sits directly upstream of the NDP clock generator (`clk_gen`) and drives that block's active-low `reset_in`. It confirms that the divided clock is actually toggling, then releases the NDP datapath reset aligned just after a slow-clock edge. It also provides a req/ack soft-reset handshake and a sticky fault flag for a divider that never starts.

## Interface
- `SYNC_STAGES`, 2: reset-deassertion synchronizer depth; must be ≥ 2.
- `HOLD_CYCLES`, 16: cycles `clk_gen_reset_n` is held low before the divider is released; must be ≥ 1.
- `RATIO`, 5: must match the `clk_gen` RATIO. Used only for the timeout.
- `LOCK_EDGES`, 2: `clock_slower` toggles required before READY; must be ≥ 1.
- `original_clock`  in  1  sole clock; all logic is on its rising edge.
- `reset_in`  in  1  asynchronous, active-low reset. Assertion is immediate; deassertion is synchronized internally.
- `soft_reset_req`  in  1  level request for a full re-sequence.
- `soft_reset_ack`  out  1  high while a soft reset is being held.
- `clock_slower_mon`  in  1  `clock_slower` from `clk_gen`, sampled as data.
- `clk_gen_reset_n`  out  1  drives `clk_gen` `reset_in`.
- `ndp_reset_n`  out  1  active-low reset for the NDP datapath.
- `ready`  out  1  sequence complete.
- `error`  out  1  sticky lock-timeout flag.
- `state`  out  3  current FSM state encoding, for debug.

## Operation
- All outputs are registered.
- On `reset_in` = 0, all of the following take effect asynchronously, at any point including mid-sequence:
  - `clk_gen_reset_n`, `ndp_reset_n`, `ready`, `error` and `soft_reset_ack` go to 0.
  - `state` goes to ASSERT (0).
  - All counters and the synchronizer clear.
- FSM states:
  - **ASSERT (0):** wait until the synchronizer output is 1, then go to HOLD with the counter at 0.
  - **HOLD (1):** `clk_gen_reset_n` = 0. Count cycles; at count == HOLD_CYCLES−1, go to DIV_START.
  - **DIV_START (2):** `clk_gen_reset_n` = 1, and stays 1 in LOCK and READY. Clear the edge counter and the timeout counter. Set the previous-sample register to 0, which is `clk_gen`'s reset value. Go to LOCK next cycle.
  - **LOCK (3):** a toggle is `clock_slower_mon` ≠ previous sample; each toggle increments the edge counter.
    - When the LOCK_EDGES-th toggle is seen, go to READY.
    - If TIMEOUT = 4·RATIO·LOCK_EDGES cycles elapse in LOCK without that, go to FAULT.
    - If both happen in the same cycle, READY wins.
  - **READY (4):** `ndp_reset_n` = 1 and `ready` = 1. If `soft_reset_req` = 1, go to SOFT.
  - **SOFT (5):** `clk_gen_reset_n`, `ndp_reset_n` and `ready` = 0; `soft_reset_ack` = 1; `error` clears. When `soft_reset_req` = 0, go to HOLD with the counter cleared.
  - **FAULT (6):** `error` = 1 (sticky); `clk_gen_reset_n` and `ndp_reset_n` = 0. Exits only via `soft_reset_req` = 1 (to SOFT) or `reset_in`.
- `soft_reset_req` is ignored in ASSERT, HOLD, DIV_START and LOCK; `soft_reset_ack` stays 0 there.
- Code 7 is unused. If the FSM ever reaches it, it goes to ASSERT.
- Counter width is `$clog2(max(HOLD_CYCLES, TIMEOUT)+1)`. Counters saturate and never wrap.

## Timing
- `reset_in` rising to leaving ASSERT: SYNC_STAGES cycles.
- HOLD lasts exactly HOLD_CYCLES cycles. DIV_START lasts 1 cycle.
- With a healthy `clk_gen`:
  - the first toggle arrives RATIO+1 cycles after `clk_gen_reset_n` rises (the extra cycle is clk_gen's sampling);
  - READY is reached ≤ LOCK_EDGES·RATIO+2 cycles after DIV_START.
- `ndp_reset_n` rises exactly 1 cycle after the cycle in which the final toggle is sampled.
- `soft_reset_ack` rises 1 cycle after `soft_reset_req` is sampled high in READY or FAULT. It falls 1 cycle after `soft_reset_req` is sampled low.
- Requester rule: hold `soft_reset_req` until `soft_reset_ack` = 1, then drop it.

## Structure
- Package `ndp_pkg` holds:
  - the `ndp_rst_state_t` typedef: 3-bit encodings ASSERT=0 … FAULT=6;
  - the TIMEOUT function of RATIO and LOCK_EDGES.
- Sub-module `ndp_reset_sync`: a SYNC_STAGES-deep flop chain, asynchronously cleared by `reset_in`, shifting in 1. One instance.
- The FSM, counters and edge detect stay in the top level.

## Test plan
All scenarios instantiate `clk_gen` with RATIO=5 as the DUT load, with HOLD_CYCLES=16 and LOCK_EDGES=2.
- **Power-up:** release `reset_in` → `clk_gen_reset_n` rises 2+16 cycles later (+1 for DIV_START). `ndp_reset_n` and `ready` rise ≤ 12 cycles after that. `error` = 0 throughout.
- **Dead divider:** hold `clock_slower_mon` at 0 → FAULT after exactly 40 cycles in LOCK, with `error` = 1, `state` = 6, and `ndp_reset_n` = 0 held indefinitely.
- **Soft reset from READY:** assert `soft_reset_req` → `soft_reset_ack` = 1 next cycle and `ready` = 0. Drop `soft_reset_req` → HOLD for 16 cycles, then READY again.
- **Recovery from FAULT:** apply `soft_reset_req` with the divider healthy → `error` clears in SOFT, then READY.
- **Mid-sequence reset:** pulse `reset_in` low during LOCK and, separately, during HOLD → every output is 0 in the same cycle and `state` = 0. After release, the full sequence reruns from ASSERT.
- **Ignored request:** hold `soft_reset_req` = 1 throughout HOLD and LOCK → `soft_reset_ack` stays 0. The FSM enters READY, then SOFT one cycle later.
